// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch controller and its byte assembler.
package if_fetch_pkg;

   localparam int InstAddrBus = 32;
   localparam int NUM_LANES   = 4;

   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_FILL = 2'd1,
      STATE_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/if_fetch_asm.sv
// Little-endian 4-byte word assembler used during an icache refill.
// word_nxt_o already includes the byte being stored this cycle, so the
// controller can register the complete word on the same edge as the last byte.
module if_fetch_asm
   import if_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        store_i,
   input  logic [7:0]  byte_i,
   output logic        done_o,
   output logic        last_o,
   output logic [31:0] word_nxt_o
);

   logic [NUM_LANES-1:0][7:0] lanes_q, lanes_d;
   logic [1:0]                rcv_cnt_q;
   logic                      done_q;

   // Merge the incoming byte into its lane
   always_comb begin
      lanes_d = lanes_q;
      if (store_i) lanes_d[rcv_cnt_q] = byte_i;
   end

   assign word_nxt_o = lanes_d;
   assign last_o     = store_i & (rcv_cnt_q == 2'd3);
   assign done_o     = done_q;

   // Lane storage and receive counter; clear wins over store
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes_q   <= '0;
         rcv_cnt_q <= 2'd0;
         done_q    <= 1'b0;
      end else if (clear_i) begin
         lanes_q   <= '0;
         rcv_cnt_q <= 2'd0;
         done_q    <= 1'b0;
      end else if (store_i) begin
         lanes_q   <= lanes_d;
         rcv_cnt_q <= rcv_cnt_q + 2'd1;
         if (rcv_cnt_q == 2'd3) done_q <= 1'b1;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch controller: probes the icache, and on a miss refills the
// line byte-by-byte over the shared 8-bit memory port before responding.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int ADDR_W = InstAddrBus
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_pc_i,
   input  logic              flush_i,
   output logic              if_valid_o,
   output logic [31:0]       if_inst_o,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic [ADDR_W-1:0] ic_raddr_o,
   input  logic              ic_hit_i,
   input  logic [31:0]       ic_inst_i,
   output logic              ic_we_o,
   output logic [ADDR_W-1:0] ic_waddr_o,
   output logic [31:0]       ic_winst_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic [7:0]        mem_data_i
);

   state_e            state_q;
   logic [ADDR_W-1:0] fill_pc_q;
   logic [ADDR_W-1:0] pc_q;
   logic [31:0]       inst_q;
   logic [2:0]        iss_cnt_q;   // bit 2 = all four bytes issued
   logic              gnt_q;
   logic              valid_q;
   logic              we_q;

   logic              grant;
   logic              miss_start;
   logic              asm_clear, asm_store, asm_done, asm_last;
   logic [31:0]       asm_word;

   assign ic_raddr_o = if_pc_i;

   // Byte requests decoded straight from registered state
   assign mem_req_o  = rdy & (state_q == STATE_FILL) & ~iss_cnt_q[2];
   assign mem_addr_o = fill_pc_q + ADDR_W'(iss_cnt_q[1:0]);
   assign grant      = mem_req_o & mem_gnt_i;

   assign miss_start = (state_q == STATE_IDLE) & if_req_i & ~ic_hit_i;
   assign asm_clear  = rdy & (flush_i | miss_start);
   assign asm_store  = rdy & ~flush_i & (state_q == STATE_FILL) & gnt_q & ~asm_done;

   if_fetch_asm u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (asm_clear),
      .store_i    (asm_store),
      .byte_i     (mem_data_i),
      .done_o     (asm_done),
      .last_o     (asm_last),
      .word_nxt_o (asm_word)
   );

   // Strobes are held low while frozen so a stalled pipeline never sees a repeat
   assign if_valid_o = valid_q & rdy;
   assign ic_we_o    = we_q & rdy;
   assign if_inst_o  = inst_q;
   assign if_pc_o    = pc_q;
   assign ic_waddr_o = pc_q;
   assign ic_winst_o = inst_q;

   // Fetch FSM: hit response, refill issue/receive, single-cycle write+respond
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= STATE_IDLE;
         fill_pc_q <= '0;
         pc_q      <= '0;
         inst_q    <= '0;
         iss_cnt_q <= 3'd0;
         gnt_q     <= 1'b0;
         valid_q   <= 1'b0;
         we_q      <= 1'b0;
      end else if (rdy) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         if (flush_i) begin
            state_q   <= STATE_IDLE;
            iss_cnt_q <= 3'd0;
            gnt_q     <= 1'b0;
         end else begin
            case (state_q)
               STATE_IDLE: begin
                  if (if_req_i) begin
                     if (ic_hit_i) begin
                        valid_q <= 1'b1;
                        inst_q  <= ic_inst_i;
                        pc_q    <= if_pc_i;
                     end else begin
                        fill_pc_q <= if_pc_i;
                        iss_cnt_q <= 3'd0;
                        gnt_q     <= 1'b0;
                        state_q   <= STATE_FILL;
                     end
                  end
               end
               STATE_FILL: begin
                  gnt_q <= grant;
                  if (grant) iss_cnt_q <= iss_cnt_q + 3'd1;
                  if (asm_last) begin
                     state_q <= STATE_RESP;
                     valid_q <= 1'b1;
                     we_q    <= 1'b1;
                     inst_q  <= asm_word;
                     pc_q    <= fill_pc_q;
                  end
               end
               STATE_RESP: state_q <= STATE_IDLE;
               default:    state_q <= STATE_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch controller: the requester and refill writer for the direct-mapped instruction cache. It takes a PC from the IF stage and probes the cache combinationally. On a hit it returns the instruction. On a miss it reads the word byte-by-byte over the shared 8-bit memory port, writes it into the cache, then returns it. It sits between the IF stage, the instruction cache, and the memory arbiter.

## Interface
- ADDR_W, 32, instruction address width (InstAddrBus)
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  global enable; low freezes all state
- if_req_i  in  1  IF stage requests fetch at if_pc_i (level)
- if_pc_i  in  ADDR_W  fetch address, word-aligned
- flush_i  in  1  abort current fetch (branch redirect)
- if_valid_o  out  1  one-cycle pulse: if_inst_o/if_pc_o valid
- if_inst_o  out  32  fetched instruction
- if_pc_o  out  ADDR_W  PC of if_inst_o
- ic_raddr_o  out  ADDR_W  cache probe address (= if_pc_i, combinational)
- ic_hit_i  in  1  cache hit for ic_raddr_o
- ic_inst_i  in  32  cache data for ic_raddr_o
- ic_we_o  out  1  cache write strobe
- ic_waddr_o  out  ADDR_W  cache write address
- ic_winst_o  out  32  cache write data
- mem_req_o  out  1  byte read request
- mem_addr_o  out  ADDR_W  byte address
- mem_gnt_i  in  1  arbiter accepted request this cycle
- mem_data_i  in  8  byte data, valid the cycle after a grant

## Operation
- States: IDLE, FILL, RESP.
- IDLE, if_req_i=1, flush_i=0:
  - ic_hit_i=1: latch ic_inst_i and if_pc_i; if_valid_o=1 next cycle; remain IDLE.
  - ic_hit_i=0: latch pc into fill_pc; clear iss_cnt and rcv_cnt (2 bits + done flag each); go to FILL.
- FILL:
  - mem_req_o=1 while iss_cnt<4; mem_addr_o=fill_pc+iss_cnt.
  - On mem_gnt_i: iss_cnt++. Set gnt_q=1 for the next cycle.
  - When gnt_q=1: store mem_data_i into byte lane rcv_cnt (little-endian, byte 0 → bits 7:0); rcv_cnt++.
  - After the 4th byte is stored, go to RESP.
- RESP (one cycle):
  - ic_we_o=1, ic_waddr_o=fill_pc, ic_winst_o=assembled word.
  - if_valid_o=1 with the same word and fill_pc.
  - Go to IDLE.
- flush_i=1, any state:
  - Next state IDLE; gnt_q, iss_cnt, rcv_cnt cleared.
  - if_valid_o and ic_we_o are 0 in the next cycle. No partial word is ever written.
  - A byte already in flight is discarded.
  - flush_i overrides a simultaneous if_req_i.
- A request is not accepted while in FILL/RESP. The IF stage holds if_req_i until if_valid_o, or drops it on flush.
- rdy=0: no register updates; mem_req_o, ic_we_o and if_valid_o are forced 0. A grant received while rdy=0 is ignored.
- Reset: state IDLE; all counters and gnt_q are 0; if_valid_o=0, ic_we_o=0, mem_req_o=0; data/address outputs are 0.

## Timing
- Hit: request at cycle t → if_valid_o at t+1.
- Miss with back-to-back grants: FILL begins t+1; grants t+1..t+4; bytes captured t+2..t+5; RESP (ic_we_o, if_valid_o) at t+6. Miss latency is 6 cycles minimum.
- A grant gap of n cycles adds n cycles.
- Issue and receive overlap: the next byte request is driven in the same cycle the previous byte returns.
- ic_raddr_o is combinational from if_pc_i. All other outputs are registered, except mem_req_o and mem_addr_o, which are decoded from registered state.
- Reset mid-FILL: immediate return to IDLE with no cache write. The next byte arriving from memory is ignored because gnt_q=0.

## Structure
- Shared defines package:
  - InstAddrBus
  - state encodings (STATE_IDLE, STATE_FILL, STATE_RESP)
  - byte-lane count 4
- One natural sub-module: if_fetch_asm, a 4-byte little-endian assembler with rcv_cnt, clear and done. The FSM stays in if_fetch.

## Test plan
- Hit: icache preloaded 0x100→0x00500093; request 0x100 → if_valid_o next cycle with inst 0x00500093; no mem_req_o.
- Miss: memory bytes at 0x200..0x203 = 13,05,A0,00; continuous grants → addresses 0x200..0x203 issued; ic_we_o at 0x200 with 0x00A00513 and if_valid_o at request+6. A re-request is then a hit.
- Grant stalls: mem_gnt_i low for 3 cycles between bytes 1 and 2 → same word; if_valid_o 3 cycles later.
- Flush after 2 bytes received → no ic_we_o, no if_valid_o. A new miss to 0x300 returns the correct word, unaffected by the stale in-flight byte.
- rdy low for 5 cycles mid-FILL → counters frozen; no mem_req_o; correct word after rdy returns.
- rst asserted mid-FILL → all outputs 0 immediately; cache not written.
